// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM state constants and op-decode helpers for muldiv_iter_unit
package muldiv_pkg;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_FIX   = 2'd2;
  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction
endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-division step (shift in dividend bit, trial subtract)
module muldiv_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);
  logic [W:0] t;
  always_comb begin
    t = {rem_i, bit_i};
    q_o = t >= {1'b0, dvsr_i};
    rem_o = q_o ? W'(t - {1'b0, dvsr_i}) : t[W-1:0];
  end
endmodule

// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO, one bit per cycle.
// Optional MULDIV_EARLY_TERM_EN ends multiplies once the remaining multiplier is zero.
module muldiv_iter_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CNT_W = $clog2(WIDTH);
  logic [1:0] st_q, st_d, op_q, op_d;
  logic sa_q, sa_d, sb_q, sb_d, done_q, done_d, dz_q, dz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, b_q, b_d, prod;
  logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] rs_mag, rt_mag, rem_n, quo, rem;
  logic q_n, sgn_rs, sgn_rt, dz_start, last;
  assign sgn_rs = is_signed_op(op) & rs_val[WIDTH-1];
  assign sgn_rt = is_signed_op(op) & rt_val[WIDTH-1];
  assign rs_mag = sgn_rs ? -rs_val : rs_val;
  assign rt_mag = sgn_rt ? -rt_val : rt_val;
  assign dz_start = start && is_div(op) && rt_val == '0;
  assign prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo = (sa_q ^ sb_q) ? -m_q : m_q;
  assign rem = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
`ifdef MULDIV_EARLY_TERM_EN
  assign last = cnt_q == '0 || (!is_div(op_q) && (m_q >> 1) == '0);
`else
  assign last = cnt_q == '0;
`endif
  // Divide reuses acc_q[WIDTH-1:0] as the partial remainder and m_q as dividend/quotient shifter
  muldiv_div_step #(.W(WIDTH)) u_step (
    .rem_i (acc_q[WIDTH-1:0]),
    .bit_i (m_q[WIDTH-1]),
    .dvsr_i(b_q[WIDTH-1:0]),
    .rem_o (rem_n),
    .q_o   (q_n)
  );
  always_comb begin
    st_d = st_q;
    op_d = op_q;
    sa_d = sa_q;
    sb_d = sb_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    b_d = b_q;
    m_d = m_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    dz_d = dz_q;
    case (st_q)
      ST_IDLE: begin
        hi_d = mthi ? rs_val : hi_q;
        lo_d = mtlo ? rs_val : lo_q;
        if (start) begin
          dz_d = dz_start;
          done_d = dz_start;
        end
        if (start && !dz_start) begin
          op_d = op;
          sa_d = sgn_rs;
          sb_d = sgn_rt;
          cnt_d = CNT_W'(WIDTH - 1);
          acc_d = '0;
          b_d = (2*WIDTH)'(is_div(op) ? rt_mag : rs_mag);
          m_d = is_div(op) ? rs_mag : rt_mag;
          st_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = is_div(op_q) ? (2*WIDTH)'(rem_n) : (m_q[0] ? acc_q + b_q : acc_q);
        b_d = is_div(op_q) ? b_q : b_q << 1;
        m_d = is_div(op_q) ? {m_q[WIDTH-2:0], q_n} : m_q >> 1;
        cnt_d = cnt_q - CNT_W'(1);
        st_d = last ? ST_FIX : ST_CALC;
      end
      ST_FIX: begin
        hi_d = is_div(op_q) ? rem : prod[2*WIDTH-1:WIDTH];
        lo_d = is_div(op_q) ? quo : prod[WIDTH-1:0];
        done_d = 1'b1;
        st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q <= ST_IDLE;
      op_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      b_q <= '0;
      m_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      st_q <= st_d;
      op_q <= op_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      b_q <= b_d;
      m_q <= m_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
      dz_q <= dz_d;
    end
  end
  assign busy = st_q != ST_IDLE;
  assign done = done_q;
  assign div_zero = dz_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// tb_muldiv_iter_unit: directed and random checks of muldiv_iter_unit against an arithmetic model.
// Honours MULDIV_EARLY_TERM_EN for expected latencies.
module tb_muldiv_iter_unit;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic busy, done, div_zero;
  logic [31:0] hi_out, lo_out;
  int n_cmp = 0, n_err = 0;
  bit chk_en = 1'b0;
  logic [31:0] e_hi = '0, e_lo = '0, p_hi = '0, p_lo = '0;
  logic e_done = 1'b0, e_dz = 1'b0, e_busy = 1'b0;
  int busy_left = 0;
`ifdef MULDIV_EARLY_TERM_EN
  localparam int LAT_M2 = 4, LAT_M5 = 5, PULSE_AT = 2;
`else
  localparam int LAT_M2 = 34, LAT_M5 = 34, PULSE_AT = 5;
`endif
  muldiv_iter_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .div_zero(div_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Result as {hi, lo} from plain 64-bit arithmetic; SV / and % truncate toward zero
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] p, qv, rv;
    x = o[0] ? longint'({32'b0, a}) : longint'($signed(a));
    y = o[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (!o[1]) begin
      p = 64'(x * y);
      return p;
    end
    q = x / y;
    r = x % y;
    qv = 64'(q);
    rv = 64'(r);
    return {rv[31:0], qv[31:0]};
  endfunction
  function automatic int calc_cycles(input logic [1:0] o, input logic [31:0] b);
    int n;
    logic [31:0] m;
    n = 32;
`ifdef MULDIV_EARLY_TERM_EN
    if (!o[1]) begin
      m = (!o[0] && b[31]) ? -b : b;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    end
`else
    m = b;
`endif
    return n;
  endfunction
  always @(posedge clk) begin
    logic [63:0] r;
    if (!reset) begin
      e_hi = '0; e_lo = '0; e_done = 1'b0; e_dz = 1'b0; busy_left = 0;
    end else begin
      e_done = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          e_hi = p_hi; e_lo = p_lo; e_done = 1'b1;
        end
      end else begin
        if (mthi) e_hi = rs_val;
        if (mtlo) e_lo = rs_val;
        if (start) begin
          if (op[1] && rt_val == 0) begin
            e_done = 1'b1; e_dz = 1'b1;
          end else begin
            e_dz = 1'b0;
            r = ref_res(op, rs_val, rt_val);
            p_hi = r[63:32]; p_lo = r[31:0];
            busy_left = calc_cycles(op, rt_val) + 1;
          end
        end
      end
    end
    e_busy = busy_left > 0;
  end
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("div_zero", div_zero, e_dz);
      check("hi", hi_out, e_hi);
      check("lo", lo_out, e_lo);
    end
  end
  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction
  task automatic poke(input logic h, input logic l, input logic [31:0] v);
    @(negedge clk);
    mthi = h; mtlo = l; rs_val = v;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
  endtask
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int xlat, input logic [31:0] xhi, input logic [31:0] xlo, input logic xdz,
                        input int pulse);
    int lat;
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      start = lat == pulse;
      mthi = lat == pulse;
      if (lat == pulse) rs_val = 32'hDEADBEEF;
      @(negedge clk);
      lat++;
    end
    start = 1'b0; mthi = 1'b0;
    check({nm, "_latency"}, lat, xlat);
    check({nm, "_hilo"}, {hi_out, lo_out}, {xhi, xlo});
    check({nm, "_model"}, {e_hi, e_lo}, {xhi, xlo});
    check({nm, "_dz"}, div_zero, xdz);
  endtask
  initial begin
    int dones;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    reset = 1'b1;
    check("reset_state", {busy, done, div_zero, hi_out, lo_out}, '0);
    run_op("mult_neg", 2'b00, 32'hFFFFFFFF, 32'h2, LAT_M2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 0);
    run_op("multu", 2'b01, 32'hFFFFFFFF, 32'h2, LAT_M2, 32'h1, 32'hFFFFFFFE, 1'b0, 0);
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'h2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 34, 32'h0, 32'h80000000, 1'b0, 0);
    poke(1'b1, 1'b0, 32'h11);
    poke(1'b0, 1'b1, 32'h22);
    run_op("divu_zero", 2'b11, 32'h7, 32'h0, 1, 32'h11, 32'h22, 1'b1, 0);
    check("divu_zero_busy", busy, 1'b0);
    poke(1'b1, 1'b1, 32'hABCD);
    check("mthi_mtlo_both", {hi_out, lo_out}, {32'hABCD, 32'hABCD});
    run_op("multu_ignore", 2'b01, 32'h3, 32'h5, LAT_M5, 32'h0, 32'hF, 1'b0, PULSE_AT);
    run_op("divu", 2'b11, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 0);
    @(negedge clk);
    op = 2'b11; rs_val = 32'd1000; rt_val = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_state", {busy, hi_out, lo_out}, '0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      start = ($urandom % 4) == 0;
      mthi = ($urandom % 10) == 0;
      mtlo = ($urandom % 10) == 0;
      op = 2'($urandom);
      rs_val = pick();
      rt_val = ($urandom % 8) == 0 ? 32'h0 : pick();
      reset = ($urandom % 3000) != 0;
    end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; reset = 1'b1;
    repeat (40) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
Parametrised iterative multiply/divide unit with HI/LO registers; successor to the separate fixed-width Mult/div blocks and their HI/LO select muxes in the multicycle CPU.
- Implements MULT, MULTU, DIV and DIVU in one datapath, one bit per cycle, with a start/busy/done handshake toward the control unit.
- Supports MTHI/MTLO writes and flags divide-by-zero for the exception path.
- Sits beside the ALU; its HI/LO outputs feed the memToReg mux.

Parameters:
WIDTH, 32, operand and HI/LO width (≥4); iteration count equals WIDTH
CNT_W, $clog2(WIDTH), width of the iteration counter (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_val  input  WIDTH  multiplicand/dividend; also MTHI/MTLO data
rt_val  input  WIDTH  multiplier/divisor
mthi  input  1  write rs_val to HI (IDLE only)
mtlo  input  1  write rs_val to LO (IDLE only)
busy  output  1  high in CALC and FIX
done  output  1  one-cycle pulse; HI/LO hold the new result while high
div_zero  output  1  set with done when a DIV/DIVU has rt_val==0; held until next accepted start
hi_out  output  WIDTH  HI register
lo_out  output  WIDTH  LO register

Behaviour:
- Reset (reset==0 at a clock edge), including mid-operation: state←IDLE; HI, LO, busy, done, div_zero←0; any operation in flight is dropped with no done.
- States: IDLE, CALC, FIX.
- IDLE, start=1:
  - Latch op and operand sign bits; load magnitudes (|x| for signed ops, raw for unsigned); counter←WIDTH-1; clear div_zero; go to CALC.
  - Exception: DIV/DIVU with rt_val==0 stays in IDLE; next cycle done=1, div_zero=1, HI/LO unchanged.
- CALC, multiply: 2·WIDTH accumulator; each cycle add the left-shifted multiplicand if multiplier[0]==1, then multiplicand<<=1, multiplier>>=1.
- CALC, divide: restoring divide, one quotient bit per cycle.
- CALC exit: counter decrements each cycle; when counter==0, go to FIX. CALC therefore lasts exactly WIDTH cycles.
- FIX (1 cycle):
  - Multiply sign: negate the 2·WIDTH product if the op is signed and the operand signs differ.
  - Divide signs: quotient negative iff signs differ; remainder takes the dividend's sign (truncating division).
  - Write HI/LO at the edge leaving FIX, go to IDLE, and register done=1 for the following cycle.
- Results: MULT/MULTU give HI=product[2W-1:W], LO=product[W-1:0]. DIV/DIVU give LO=quotient, HI=remainder.
- Latency: start sampled at edge 0 → done high in the cycle after edge WIDTH+1, i.e. WIDTH+2 cycles. busy is high from edge 0 until the edge leaving FIX.
- Overflow case: DIV of most-negative by -1 gives LO=most-negative, HI=0, with no flag.
- Boundaries:
  - start while busy is ignored.
  - mthi/mtlo while busy are ignored.
  - mthi/mtlo together with start: both writes happen, then the operation starts.
  - mthi and mtlo together: both registers take rs_val.
  - Arithmetic is modulo WIDTH / 2·WIDTH; no saturation.

Optional Feature:
MULDIV_EARLY_TERM_EN
- Defined: MULT/MULTU leave CALC for FIX as soon as the post-update multiplier register is zero, or when the counter expires. Minimum of 1 CALC cycle; divides are unaffected. Latency = (CALC cycles)+2.
- Undefined: fixed WIDTH CALC cycles for all ops.

Decomposition:
- muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and state enum (ST_IDLE, ST_CALC, ST_FIX).
- One sub-module, muldiv_div_step: combinational restoring step that takes remainder, dividend bit and divisor and returns the next remainder and quotient bit.
- All other logic lives in muldiv_iter_unit.

Test Plan:
1. MULT rs=0xFFFFFFFF, rt=0x00000002 → done at start+34, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
2. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE. Under MULDIV_EARLY_TERM_EN, done at start+4.
3. DIV rs=0xFFFFFFF9 (-7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
4. DIVU rs=7, rt=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo → done and div_zero at start+1, HI=0x11, LO=0x22, busy never rises.
5. MULTU 3×5 with start re-pulsed and mthi=1 at cycle 5 → both ignored; result HI=0, LO=15. Then DIVU 100/7 → LO=14, HI=2, div_zero=0.
6. DIVU started, reset=0 at cycle 10 → next cycle busy=0, HI=LO=0, no done pulse.
